// File: rtl/i2c_target_regs.sv
// I2C target exposing an auto-incrementing byte register port to an external bus initiator.
// SCL/SDA are synchronized and glitch-filtered; SDA is driven open-drain through sda_oe.
module i2c_target_regs #(
    parameter logic [6:0] C_addr   = 7'h42,
    parameter int         C_aw     = 4,
    parameter int         C_filter = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            scl_i,
    input  logic            sda_i,
    output logic            sda_oe,
    output logic            wr_strobe,
    output logic [C_aw-1:0] wr_addr,
    output logic [7:0]      wr_data,
    output logic [C_aw-1:0] rd_addr,
    input  logic [7:0]      rd_data,
    output logic            rd_strobe,
    output logic            busy
);

    localparam int              C_fw   = $clog2(C_filter + 1);
    localparam logic [C_fw-1:0] C_fmax = C_fw'(C_filter - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_REG      = 3'd3;
    localparam logic [2:0] ST_WDATA    = 3'd4;
    localparam logic [2:0] ST_WACK     = 3'd5;
    localparam logic [2:0] ST_RDATA    = 3'd6;
    localparam logic [2:0] ST_RACK     = 3'd7;

    // Index 0 is SCL, index 1 is SDA throughout the input path.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            filt_q, filt_d;
    logic [1:0]            filt_p_q;
    logic [1:0][C_fw-1:0]  fcnt_q, fcnt_d;

    logic [2:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      tx_q, tx_d;
    logic [C_aw-1:0] ptr_q, ptr_d;
    logic            sda_oe_q, sda_oe_d;
    logic            rw_q, rw_d;
    logic            mack_q, mack_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [C_aw-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            rd_load;

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

    // A level change is accepted only after C_filter consecutive differing samples.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == C_fmax) filt_d[i] = sync2_q[i];
                else                     fcnt_d[i] = fcnt_q[i] + C_fw'(1);
            end
        end
    end

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = filt_q[0] & ~filt_p_q[0];
    assign scl_fall  = ~filt_q[0] & filt_p_q[0];
    assign start_det = filt_p_q[1] & ~filt_q[1] & scl_f;
    assign stop_det  = ~filt_p_q[1] & filt_q[1] & scl_f;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_load     = 1'b0;

        // Bus conditions take priority over any coincident SCL edge.
        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
        end else if (start_det) begin
            state_d  = ST_ADDR;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (scl_rise) begin
                case (state_q)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        shift_d = {shift_q[6:0], sda_f};
                        cnt_d   = cnt_q + 4'd1;
                    end
                    ST_RACK: mack_d = sda_f;
                    default: ;
                endcase
            end
            if (scl_fall) begin
                case (state_q)
                    ST_ADDR: if (cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == C_addr) begin
                            state_d  = ST_ADDR_ACK;
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (rw_q) begin
                            rd_load = 1'b1;
                        end else begin
                            state_d  = ST_REG;
                            sda_oe_d = 1'b0;
                        end
                    end
                    ST_REG: if (cnt_q == 4'd8) begin
                        ptr_d    = shift_q[C_aw-1:0];
                        sda_oe_d = 1'b1;
                        state_d  = ST_WACK;
                        cnt_d    = '0;
                    end
                    ST_WDATA: if (cnt_q == 4'd8) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = shift_q;
                        ptr_d       = ptr_q + C_aw'(1);
                        sda_oe_d    = 1'b1;
                        state_d     = ST_WACK;
                        cnt_d       = '0;
                    end
                    ST_WACK: begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                        cnt_d    = '0;
                    end
                    ST_RDATA: begin
                        if (cnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RACK;
                            cnt_d    = '0;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                    ST_RACK: begin
                        if (!mack_q) begin
                            rd_load = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Shared byte-load for the first read byte and every initiator-ACKed byte.
        if (rd_load) begin
            tx_d     = rd_data;
            sda_oe_d = ~rd_data[7];
            ptr_d    = ptr_q + C_aw'(1);
            cnt_d    = '0;
            state_d  = ST_RDATA;
        end
    end

    // NOTE: sda_oe comes straight from an async-reset flop, so asserting resetn releases SDA at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_p_q    <= 2'b11;
            fcnt_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            sync1_q     <= {sda_i, scl_i};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_p_q    <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_addr   = ptr_q;
    assign rd_strobe = rd_load;
    assign busy      = (state_q != ST_IDLE);

endmodule
